shift_sequencer: RTL and testbench

//  Multi-cycle controller for the CPU's shift datapath (SLL/SRL/SRA and variable forms SLLV/SRLV/SRAV).

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_step.sv | 24 ++
 rtl/shift_sequencer.sv | 109 ++++++++++
 tb/tb_shift_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: operand width,
// shift operation encodings, FSM state encoding and the amount zero-extender.
package shift_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_FIN   = 2'b10
  } state_e;

  // Ext5 path: the 5-bit shift amount becomes a 32-bit value with the upper 27 bits clear.
  function automatic logic [DATA_W-1:0] zext_amt(input logic [4:0] amt);
    return {27'b0, amt};
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step: shifts the accumulator by n (0..STEP) bits.
// The reserved opcode behaves as SLL.
module shift_step
  import shift_pkg::*;
#(
  parameter int NW = 4
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [NW-1:0]     n_i,
  input  op_e               op_i,
  output logic [DATA_W-1:0] res_o
);

  // Select the shift flavour; SRA replicates the accumulator sign bit.
  always_comb begin
    res_o = acc_i;
    case (op_i)
      OP_SRL:  res_o = acc_i >> n_i;
      OP_SRA:  res_o = $unsigned($signed(acc_i) >>> n_i);
      default: res_o = acc_i << n_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller replacing a full barrel shifter. The operand is
// shifted STEP bits per cycle; busy stalls the pipeline until the FIN state.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int STEP  = 1,
  parameter int WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [1:0]        op,
  input  logic              var_sel,
  input  logic [WIDTH-1:0]  shamt,
  input  logic [WIDTH-1:0]  rs_lo,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done
);

  localparam int NW = 4;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  op_e               op_q, op_d;
  logic [NW-1:0]     n_s;
  logic [DATA_W-1:0] step_res_s;

  // Step size clamped to the remaining count so cnt can never wrap below zero.
  always_comb begin
    if (cnt_q > WIDTH'(STEP)) begin
      n_s = NW'(STEP);
    end else begin
      n_s = NW'(cnt_q);
    end
  end

  shift_step #(.NW(NW)) u_step (
    .acc_i (acc_q),
    .n_i   (n_s),
    .op_i  (op_q),
    .res_o (step_res_s)
  );

  // Next-state logic: latch request in IDLE, shift in SHIFT, publish on entry to FIN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          acc_d   = data_in;
          cnt_d   = WIDTH'(zext_amt(var_sel ? rs_lo : shamt));
          op_d    = op_e'(op);
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          result_d = acc_q;
          state_d  = S_FIN;
        end else begin
          acc_d = step_res_s;
          cnt_d = cnt_q - WIDTH'(n_s);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= 32'h0000_0000;
      op_q     <= OP_SLL;
      result_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // Status decodes depend only on the state register, never on inputs.
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_FIN);
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a STEP=1 and a STEP=8 instance share inputs;
// a vector table covers the shift functions, hand sequences cover busy/flush/reset.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        var_sel = 1'b0;
  logic [4:0]  shamt = 5'd0;
  logic [4:0]  rs_lo = 5'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] result1, result8;
  logic        busy1, busy8, done1, done8;

  int vecs = 0;
  int misses = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.STEP(1), .WIDTH(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .var_sel(var_sel), .shamt(shamt), .rs_lo(rs_lo), .data_in(data_in),
    .result(result1), .busy(busy1), .done(done1)
  );

  shift_sequencer #(.STEP(8), .WIDTH(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .var_sel(var_sel), .shamt(shamt), .rs_lo(rs_lo), .data_in(data_in),
    .result(result8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic        use8;
    logic [1:0]  op;
    logic        var_sel;
    logic [4:0]  shamt;
    logic [4:0]  rs_lo;
    logic [31:0] data;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy1 || busy8) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", {31'b0, busy1 | busy8}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    logic seen;
    wait_idle();
    @(negedge clk);
    op = v.op; var_sel = v.var_sel; shamt = v.shamt; rs_lo = v.rs_lo;
    data_in = v.data; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_busy", idx), {31'b0, v.use8 ? busy8 : busy1}, 32'd1);
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (v.use8 ? done8 : done1) begin
        seen = 1'b1;
        lat = k;
      end
    end
    chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_res", idx), v.use8 ? result8 : result1, v.exp_res);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), {31'b0, v.use8 ? done8 : done1}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic seen;

    tbl[0]  = '{1'b0, 2'd0, 1'b0, 5'd31, 5'd0,  32'h0000_0001, 32'h8000_0000, 32};
    tbl[1]  = '{1'b0, 2'd2, 1'b1, 5'd17, 5'd4,  32'h8000_0000, 32'hF800_0000, 5};
    tbl[2]  = '{1'b0, 2'd1, 1'b1, 5'd17, 5'd4,  32'h8000_0000, 32'h0800_0000, 5};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 5'd0,  5'd9,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
    tbl[4]  = '{1'b0, 2'd3, 1'b0, 5'd4,  5'd2,  32'h0000_000F, 32'h0000_00F0, 5};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 5'd8,  5'd0,  32'h7FFF_0000, 32'h007F_FF00, 9};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 5'd31, 5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 5'd31, 5'd0,  32'h8000_0001, 32'hFFFF_FFFF, 32};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 5'd13, 5'd0,  32'h0000_00FF, 32'h001F_E000, 3};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 5'd31, 5'd0,  32'h8000_0000, 32'hFFFF_FFFF, 5};
    tbl[10] = '{1'b1, 2'd0, 1'b0, 5'd0,  5'd0,  32'hCAFE_F00D, 32'hCAFE_F00D, 1};
    tbl[11] = '{1'b1, 2'd1, 1'b1, 5'd3,  5'd8,  32'h1234_5678, 32'h0012_3456, 2};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_result1", result1, 32'd0);
    chk("rst_flags1", {29'b0, busy1, done1, 1'b0}, 32'd0);
    chk("rst_result8", result8, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    // Start re-pulsed with new data while busy: only the first request counts.
    wait_idle();
    @(negedge clk);
    op = 2'd0; var_sel = 1'b0; shamt = 5'd3; data_in = 32'h0000_0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 2'd1; shamt = 5'd1; data_in = 32'h0000_FFFF;
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1) begin
        seen = 1'b1;
        lat = k;
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("busy_start_lat", 32'(lat), 32'd4);
    chk("busy_start_res", result1, 32'h0000_0008);
    @(negedge clk);
    chk("busy_start_idle", {31'b0, busy1}, 32'd0);

    // Flush mid-SHIFT: back to IDLE, no done, result unchanged.
    wait_idle();
    @(negedge clk);
    op = 2'd0; shamt = 5'd20; data_in = 32'h0000_0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy1}, 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    chk("flush_no_done", {31'b0, seen}, 32'd0);
    chk("flush_res", result1, 32'h0000_0008);

    // Reset mid-SHIFT: outputs clear at once.
    wait_idle();
    @(negedge clk);
    shamt = 5'd20; data_in = 32'h0000_ABCD; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_res1", result1, 32'd0);
    chk("midrst_flags", {30'b0, busy1, done1}, 32'd0);
    chk("midrst_res8", result8, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
    $finish;
  end

endmodule
